fx3_count_checker: RTL and testbench

- Read-side companion to the counting data source. Pulls 32-bit words from the FX3 GPIF II slave FIFO (FPGA/CPLD is the master) and ping-pongs between DMA threads 0 and 1 one buffer at a time.
- Checks each word against the expected incrementing count. Reports a sticky error flag, a saturating error count and an LED progress indication.
- Used as the loopback and host-to-device throughput test on the same CPLD board.

---
 rtl/fx3_count_checker_if.sv | 31 +++
 rtl/fx3_count_checker.sv | 147 ++++++++++++++
 tb/tb_fx3_count_checker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_count_checker_if.sv
// FX3 GPIF II slave-FIFO read-side bundle: thread flags, data bus, read strobes and thread address.
// Latency: none, wires only.
// Backpressure: the FPGA side (master) throttles the FX3 by holding RD_n high; the FX3 gates via DMAx_Ready.
interface fx3_count_checker_if;
  logic        DMA0_Ready;
  logic        DMA1_Ready;
  logic [31:0] DQ;
  logic        RD_n;
  logic        OE_n;
  logic        SelectDMA;

  // FPGA/CPLD side drives the strobes and thread address
  modport master (
    input  DMA0_Ready,
    input  DMA1_Ready,
    input  DQ,
    output RD_n,
    output OE_n,
    output SelectDMA
  );

  // FX3 side answers with flags and data
  modport slave (
    output DMA0_Ready,
    output DMA1_Ready,
    output DQ,
    input  RD_n,
    input  OE_n,
    input  SelectDMA
  );
endinterface

// File: rtl/fx3_count_checker.sv
// Reads whole DMA buffers from the FX3 slave FIFO, ping-ponging threads 0/1, and checks an incrementing count.
// Latency: a word is checked RD_LATENCY edges after its RD_n-low edge; 2^BURST_LOG2+RD_LATENCY+1 cycles per buffer.
// Backpressure: bursts start only when the selected thread is ready; CHECK_RESYNC_EN resyncs Expected on mismatch.
module fx3_count_checker #(
  parameter int BURST_LOG2 = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                PCLK,
  input  logic                RESET,
  fx3_count_checker_if.master fifo,
  output logic                Error,
  output logic [15:0]         ErrorCount,
  output logic [7:0]          LED
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam logic [BURST_LOG2-1:0] LAST_WORD = '1;
  // Every pipeline stage except the output one; once these are clear the
  // word being checked on this edge is the last one in flight.
  localparam logic [RD_LATENCY-1:0] LOW_MASK  = {RD_LATENCY{1'b1}} >> 1;

  state_t                  state;
  state_t                  state_nxt;
  logic                    rd_n_nxt;
  logic                    oe_n_nxt;
  logic                    sel_nxt;
  logic                    ready;
  logic                    drain_done;
  logic                    word_vld;
  logic [BURST_LOG2-1:0]   word_cnt;
  logic [RD_LATENCY-1:0]   vld_pipe;
  logic [31:0]             expected;

  assign ready      = fifo.SelectDMA ? fifo.DMA1_Ready : fifo.DMA0_Ready;
  assign drain_done = (vld_pipe & LOW_MASK) == '0;
  assign word_vld   = vld_pipe[RD_LATENCY-1];
  assign LED        = ~expected[31:24];

  // Next-state and next registered strobe/address values
  always_comb begin
    state_nxt = state;
    rd_n_nxt  = 1'b1;
    oe_n_nxt  = fifo.OE_n;
    sel_nxt   = fifo.SelectDMA;
    case (state)
      IDLE: begin
        oe_n_nxt = 1'b1;
        if (ready) begin
          state_nxt = READ;
          rd_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
        end
      end
      READ: begin
        oe_n_nxt = 1'b0;
        if (word_cnt == LAST_WORD) begin
          state_nxt = DRAIN;
          rd_n_nxt  = 1'b1;
        end else begin
          rd_n_nxt  = 1'b0;
        end
      end
      DRAIN: begin
        oe_n_nxt = 1'b0;
        if (drain_done) begin
          sel_nxt   = ~fifo.SelectDMA;
          state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        if (ready) begin
          state_nxt = READ;
          rd_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
          oe_n_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        oe_n_nxt  = 1'b1;
      end
    endcase
  end

  // State register and registered FIFO strobes/address
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      fifo.RD_n      <= 1'b1;
      fifo.OE_n      <= 1'b1;
      fifo.SelectDMA <= 1'b0;
    end else begin
      state          <= state_nxt;
      fifo.RD_n      <= rd_n_nxt;
      fifo.OE_n      <= oe_n_nxt;
      fifo.SelectDMA <= sel_nxt;
    end
  end

  // Words issued in the current buffer; each READ edge is one read strobe
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      word_cnt <= '0;
    end else if (state == READ) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Tracks which upcoming edges carry valid DQ, one bit per read in flight
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(!fifo.RD_n);
    end
  end

  // Compare each valid word against the running count and log mismatches
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      expected   <= '0;
      Error      <= 1'b0;
      ErrorCount <= '0;
    end else if (word_vld) begin
      if (fifo.DQ == expected) begin
        expected <= expected + 32'd1;
      end else begin
        Error      <= 1'b1;
        ErrorCount <= (ErrorCount == 16'hFFFF) ? ErrorCount : ErrorCount + 16'd1;
`ifdef CHECK_RESYNC_EN
        expected   <= fifo.DQ + 32'd1;
`else
        expected   <= expected + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fx3_count_checker.sv
// Bench for fx3_count_checker: FX3 slave-FIFO model plus a word-level reference of the count checker.
// Latency: the FX3 model returns data RD_LATENCY edges after each RD_n-low edge.
// Backpressure: thread ready flags are driven by the test sequence.
module tb_fx3_count_checker;
  localparam int BL2 = 12;
  localparam int L   = 2;
  localparam int BUF = 1 << BL2;

  localparam int M_NORM  = 0;
  localparam int M_SUBST = 1;
  localparam int M_DROP  = 2;
  localparam int M_ZERO  = 3;
  localparam int M_RAND  = 4;

  logic        PCLK = 1'b0;
  logic        RESET;
  logic        Error;
  logic [15:0] ErrorCount;
  logic [7:0]  LED;

  fx3_count_checker_if bus();

  fx3_count_checker #(.BURST_LOG2(BL2), .RD_LATENCY(L)) dut (
    .PCLK       (PCLK),
    .RESET      (RESET),
    .fifo       (bus),
    .Error      (Error),
    .ErrorCount (ErrorCount),
    .LED        (LED)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  // FX3 source state and reference checker state
  int          mode      = M_NORM;
  int          rnd_start = 0;
  int          src_n     = 0;
  int          checked_cnt = 0;
  bit          hist[$];
  bit          pend_vld  = 1'b0;
  logic [31:0] pend_word = '0;
  logic [31:0] m_exp     = '0;
  int          m_errs    = 0;
  bit          m_flag    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Word the FX3 returns for the n-th read since reset
  function automatic logic [31:0] src_word(input int n);
    logic [31:0] w;
    w = 32'(n);
    case (mode)
      M_SUBST: if (n == 100) w = 32'hDEADBEEF;
      M_DROP:  if (n >= 100) w = 32'(n + 1);
      M_ZERO:  w = '0;
      M_RAND:  if (n >= rnd_start && $urandom_range(0, 31) == 0) w = $urandom;
      default: ;
    endcase
    return w;
  endfunction

  // Reference: what the checker should conclude from one received word
  function automatic void ref_apply(input logic [31:0] w);
    if (w != m_exp) begin
      m_flag = 1'b1;
      if (m_errs < 65535) m_errs++;
`ifdef CHECK_RESYNC_EN
      m_exp = w + 32'd1;
`else
      m_exp = m_exp + 32'd1;
`endif
    end else begin
      m_exp = m_exp + 32'd1;
    end
  endfunction

  initial for (int i = 0; i < L; i++) hist.push_back(1'b0);

  // FX3 model: data for a read strobe appears L edges later; word sent at
  // this negedge is consumed by the DUT on the following posedge.
  always @(negedge PCLK) begin
    if (RESET) begin
      hist.delete();
      for (int i = 0; i < L; i++) hist.push_back(1'b0);
      pend_vld    = 1'b0;
      src_n       = 0;
      checked_cnt = 0;
      m_exp       = '0;
      m_errs      = 0;
      m_flag      = 1'b0;
      bus.DQ      = '0;
    end else begin
      if (pend_vld) begin
        ref_apply(pend_word);
        checked_cnt++;
      end
      pend_vld = 1'b0;
      hist.push_back(bus.RD_n == 1'b0);
      if (hist.pop_front()) begin
        pend_word = src_word(src_n);
        src_n++;
        pend_vld  = 1'b1;
        bus.DQ    = pend_word;
      end else begin
        bus.DQ    = $urandom;
      end
    end
  end

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic do_reset(input int m);
    RESET = 1'b1;
    bus.DMA0_Ready = 1'b0;
    bus.DMA1_Ready = 1'b0;
    mode = m;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic wait_checked(input int n, input int budget, input string tag);
    int cyc = 0;
    while (checked_cnt < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_words_checked"}, 32'(checked_cnt), 32'(n));
  endtask

  task automatic chk_vs_model(input string tag);
    logic [7:0] led_exp;
    led_exp = ~m_exp[31:24];
    chk({tag, "_errcnt"}, 32'(ErrorCount), 32'(m_errs));
    chk({tag, "_error"},  32'(Error),      32'(m_flag));
    chk({tag, "_led"},    32'(LED),        32'(led_exp));
  endtask

  initial begin
    int lows, highs, sel_seen, k;
    RESET = 1'b1;
    bus.DMA0_Ready = 1'b0;
    bus.DMA1_Ready = 1'b0;
    #1;
    chk("rst_rd_n",   32'(bus.RD_n),      32'd1);
    chk("rst_oe_n",   32'(bus.OE_n),      32'd1);
    chk("rst_sel",    32'(bus.SelectDMA), 32'd0);
    chk("rst_error",  32'(Error),         32'd0);
    chk("rst_errcnt", 32'(ErrorCount),    32'd0);
    chk("rst_led",    32'(LED),           32'hFF);

    // 1: both threads ready, clean count, burst shape and thread switch
    do_reset(M_NORM);
    bus.DMA0_Ready = 1'b1;
    bus.DMA1_Ready = 1'b1;
    k = 0;
    while (bus.RD_n == 1'b1 && k < 20) begin tick(); k++; end
    lows = 0;
    while (bus.RD_n == 1'b0 && lows < 5000) begin lows++; tick(); end
    chk("t1_rd_low_run", 32'(lows), 32'(BUF));
    highs = 0;
    sel_seen = -1;
    while (bus.RD_n == 1'b1 && highs < 50) begin
      if (bus.SelectDMA && sel_seen < 0) sel_seen = checked_cnt;
      highs++;
      tick();
    end
    chk("t1_rd_high_run", 32'(highs), 32'(L + 1));
    chk("t1_sel_after_last_word", 32'(sel_seen), 32'(BUF));
    wait_checked(2 * BUF, 5000, "t1");
    chk("t1_errcnt", 32'(ErrorCount), 32'd0);
    chk("t1_error",  32'(Error),      32'd0);
    chk("t1_led",    32'(LED),        32'hFF);

    // 2: thread 1 not ready at the boundary, then resume with random corruption
    do_reset(M_NORM);
    bus.DMA0_Ready = 1'b1;
    wait_checked(BUF, 4200, "t2_buf0");
    repeat (4) tick();
    chk("t2_idle_rd_n", 32'(bus.RD_n),      32'd1);
    chk("t2_idle_oe_n", 32'(bus.OE_n),      32'd1);
    chk("t2_idle_sel",  32'(bus.SelectDMA), 32'd1);
    repeat ($urandom_range(1, 20)) tick();
    rnd_start = BUF + 4;
    mode = M_RAND;
    bus.DMA1_Ready = 1'b1;
    k = 0;
    while (bus.RD_n == 1'b1 && k < 10) begin
      @(posedge PCLK);
      #1;
      k++;
    end
    chk("t2_rd_low_within_2_edges", 32'(k >= 1 && k <= 2), 32'd1);
    wait_checked(BUF + 1, 20, "t2_first");
    chk("t2_first_word_4096_clean", 32'(ErrorCount), 32'd0);
    wait_checked(BUF + 1900, 2500, "t2_rand");
    chk_vs_model("t2_rand");

    // 3: one substituted word costs exactly one error
    do_reset(M_SUBST);
    bus.DMA0_Ready = 1'b1;
    wait_checked(101, 200, "t3_hit");
    chk("t3_error",  32'(Error),      32'd1);
    chk("t3_errcnt", 32'(ErrorCount), 32'd1);
    wait_checked(300, 300, "t3_after");
    chk("t3_errcnt_clean_after", 32'(ErrorCount), 32'd1);

    // 4: dropped word
    do_reset(M_DROP);
    bus.DMA0_Ready = 1'b1;
    wait_checked(BUF, 4200, "t4");
`ifdef CHECK_RESYNC_EN
    chk("t4_errcnt_drop", 32'(ErrorCount), 32'd1);
`else
    chk("t4_errcnt_drop", 32'(ErrorCount), 32'd3996);
`endif
    chk_vs_model("t4");

    // 5: reset mid-burst
    do_reset(M_SUBST);
    bus.DMA0_Ready = 1'b1;
    wait_checked(2000, 2200, "t5");
    chk("t5_errcnt_before", 32'(ErrorCount), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_rd_n",   32'(bus.RD_n),      32'd1);
    chk("t5_oe_n",   32'(bus.OE_n),      32'd1);
    chk("t5_sel",    32'(bus.SelectDMA), 32'd0);
    chk("t5_errcnt", 32'(ErrorCount),    32'd0);
    chk("t5_led",    32'(LED),           32'hFF);
    mode = M_NORM;
    repeat (2) tick();
    RESET = 1'b0;
    wait_checked(500, 700, "t5_restart");
    chk("t5_restart_errcnt", 32'(ErrorCount), 32'd0);
    chk_vs_model("t5_restart");

    // 6: all-zero data saturates the error counter
    do_reset(M_ZERO);
    bus.DMA0_Ready = 1'b1;
    bus.DMA1_Ready = 1'b1;
    wait_checked(65600, 70000, "t6");
    chk("t6_errcnt_sat", 32'(ErrorCount), 32'hFFFF);
    chk("t6_error",      32'(Error),      32'd1);
    chk_vs_model("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
